// File: rtl/i2c_cmd_sequencer.sv
// Command front-end for i2c_master: queues register-level I2C commands, issues them one at a
// time over the enable/busy handshake and returns one response per command.
module i2c_cmd_sequencer #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned REG_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH    = 7,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned START_TIMEOUT = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_rw,
    input  logic [ADDR_WIDTH-1:0]         i_cmd_dev_addr,
    input  logic [REG_WIDTH-1:0]          i_cmd_reg_addr,
    input  logic [DATA_WIDTH-1:0]         i_cmd_data,
    input  logic [15:0]                   i_divider,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic                          o_rsp_rw,
    output logic [DATA_WIDTH-1:0]         o_rsp_data,
    output logic                          o_rsp_err,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_enable,
    output logic                          o_rw,
    output logic [DATA_WIDTH-1:0]         o_mosi_data,
    output logic [REG_WIDTH-1:0]          o_reg_addr,
    output logic [ADDR_WIDTH-1:0]         o_device_addr,
    output logic [15:0]                   o_divider,
    input  logic                          i_busy,
    input  logic [DATA_WIDTH-1:0]         i_miso_data
);

    localparam int unsigned PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned LW      = PW + 1;
    localparam int unsigned CW      = $clog2(START_TIMEOUT + 1);
    localparam int unsigned ENTRY_W = 1 + ADDR_WIDTH + REG_WIDTH + DATA_WIDTH;

    localparam logic [PW-1:0] PtrOne  = PW'(1);
    localparam logic [LW-1:0] LvlOne  = LW'(1);
    localparam logic [LW-1:0] LvlFull = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CntOne  = CW'(1);
    localparam logic [CW-1:0] TmoLast = CW'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

    // ---------------- command FIFO ----------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]      level_q;
    logic               init_q;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] head;
    logic                   head_rw;
    logic [ADDR_WIDTH-1:0]  head_dev;
    logic [REG_WIDTH-1:0]   head_reg;
    logic [DATA_WIDTH-1:0]  head_data;

    assign full        = (level_q == LvlFull);
    assign empty       = (level_q == '0);
    // init_q keeps ready low until the first clock after reset release
    assign o_cmd_ready = init_q && !full;
    assign push        = i_cmd_valid && o_cmd_ready;
    assign head        = mem[rd_ptr_q];
    assign {head_rw, head_dev, head_reg, head_data} = head;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {i_cmd_rw, i_cmd_dev_addr, i_cmd_reg_addr, i_cmd_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            init_q   <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LvlOne;
                2'b01:   level_q <= level_q - LvlOne;
                default: level_q <= level_q;
            endcase
        end
    end

    assign o_fifo_level = level_q;

    // ---------------- issue FSM ----------------
    state_e                state_q, state_d;
    logic                  enable_q, enable_d;
    logic                  rw_q, rw_d;
    logic [DATA_WIDTH-1:0] mosi_q, mosi_d;
    logic [REG_WIDTH-1:0]  reg_q, reg_d;
    logic [ADDR_WIDTH-1:0] dev_q, dev_d;
    logic [15:0]           div_q, div_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_rw_q, rsp_rw_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            enable_q    <= 1'b0;
            rw_q        <= 1'b0;
            mosi_q      <= '0;
            reg_q       <= '0;
            dev_q       <= '0;
            div_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rw_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            rw_q        <= rw_d;
            mosi_q      <= mosi_d;
            reg_q       <= reg_d;
            dev_q       <= dev_d;
            div_q       <= div_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rw_q    <= rsp_rw_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        enable_d    = enable_q;
        rw_d        = rw_q;
        mosi_d      = mosi_q;
        reg_d       = reg_q;
        dev_d       = dev_q;
        div_d       = div_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rw_d    = rsp_rw_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        pop         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && !i_busy) begin
                    pop      = 1'b1;
                    rw_d     = head_rw;
                    mosi_d   = head_data;
                    reg_d    = head_reg;
                    dev_d    = head_dev;
                    div_d    = i_divider;
                    enable_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StLaunch;
                end
            end
            StLaunch: begin
                if (i_busy) begin
                    enable_d = 1'b0;
                    state_d  = StWait;
                end else if (cnt_q == TmoLast) begin
                    // master never started: report error without executing
                    enable_d    = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_rw_d    = rw_q;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StWait: begin
                if (!i_busy) begin
                    rsp_data_d  = rw_q ? i_miso_data : '0;
                    rsp_rw_d    = rw_q;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_enable      = enable_q;
    assign o_rw          = rw_q;
    assign o_mosi_data   = mosi_q;
    assign o_reg_addr    = reg_q;
    assign o_device_addr = dev_q;
    assign o_divider     = div_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rw      = rsp_rw_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural i2c_master/slave stand-in that
// raises busy on enable, holds it for busy_len cycles and keeps a register file.
module tb_i2c_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [6:0]  cmd_dev_addr;
    logic [7:0]  cmd_reg_addr, cmd_data;
    logic [15:0] divider;
    logic        rsp_valid, rsp_ready, rsp_rw, rsp_err;
    logic [7:0]  rsp_data;
    logic [2:0]  fifo_level;
    logic        enable, rw;
    logic [7:0]  mosi_data, reg_addr;
    logic [6:0]  device_addr;
    logic [15:0] m_divider;
    logic        busy;
    logic [7:0]  miso_data;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(
        .DATA_WIDTH   (8),
        .REG_WIDTH    (8),
        .ADDR_WIDTH   (7),
        .FIFO_DEPTH   (4),
        .START_TIMEOUT(1024)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_rw      (cmd_rw),
        .i_cmd_dev_addr(cmd_dev_addr),
        .i_cmd_reg_addr(cmd_reg_addr),
        .i_cmd_data    (cmd_data),
        .i_divider     (divider),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rw      (rsp_rw),
        .o_rsp_data    (rsp_data),
        .o_rsp_err     (rsp_err),
        .o_fifo_level  (fifo_level),
        .o_enable      (enable),
        .o_rw          (rw),
        .o_mosi_data   (mosi_data),
        .o_reg_addr    (reg_addr),
        .o_device_addr (device_addr),
        .o_divider     (m_divider),
        .i_busy        (busy),
        .i_miso_data   (miso_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // master/slave stand-in
    logic       master_on, stall, m_act, m_rw;
    int         busy_len, m_cnt;
    logic [7:0] m_reg, m_data;
    logic [7:0] regs [256];

    initial begin
        busy = 1'b0; miso_data = '0; m_act = 1'b0; m_cnt = 0;
        m_rw = 1'b0; m_reg = '0; m_data = '0;
        for (int i = 0; i < 256; i++) regs[i] = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !master_on) begin
                busy = 1'b0; m_act = 1'b0;
            end else if (stall) begin
                busy = 1'b1; m_act = 1'b0;
            end else if (!m_act) begin
                busy = 1'b0;
                if (enable) begin
                    busy = 1'b1; m_act = 1'b1; m_cnt = 0;
                    m_rw = rw; m_reg = reg_addr; m_data = mosi_data;
                end
            end else begin
                m_cnt++;
                if (m_cnt >= busy_len) begin
                    if (m_rw) miso_data = regs[m_reg];
                    else      regs[m_reg] = m_data;
                    busy = 1'b0; m_act = 1'b0;
                end
            end
        end
    end

    // call at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic r, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] d);
        int n;
        cmd_valid = 1'b1; cmd_rw = r; cmd_dev_addr = dev; cmd_reg_addr = ra; cmd_data = d;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic r, input logic [7:0] d, input logic e);
        int n;
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_rw"}, rsp_rw, r);
        check({tag, "_data"}, rsp_data, d);
        check({tag, "_err"}, rsp_err, e);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_drop"}, rsp_valid, 1'b0);
    endtask

    initial begin
        int n, bad;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_dev_addr = '0;
        cmd_reg_addr = '0; cmd_data = '0; divider = 16'h0020; rsp_ready = 1'b0;
        master_on = 1'b1; stall = 1'b0; busy_len = 4;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_enable", enable, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", cmd_ready, 1'b1);

        // 1: single write, launch latency and latched master-side fields
        push(1'b0, 7'h11, 8'h00, 8'hDC);
        check("wr1_level_before", fifo_level, 3'd1);
        check("wr1_enable_before", enable, 1'b0);
        @(negedge clk);
        check("wr1_enable", enable, 1'b1);
        check("wr1_level_popped", fifo_level, 3'd0);
        check("wr1_o_rw", rw, 1'b0);
        check("wr1_dev", device_addr, 7'h11);
        check("wr1_reg", reg_addr, 8'h00);
        check("wr1_mosi", mosi_data, 8'hDC);
        check("wr1_div", m_divider, 16'h0020);
        wait_rsp("wr1", 1'b0, 8'h00, 1'b0);

        // 2: read back
        push(1'b1, 7'h11, 8'h00, 8'h00);
        wait_rsp("rd1", 1'b1, 8'hDC, 1'b0);

        // 3: fill FIFO while master reports busy, fifth push stalls
        stall = 1'b1;
        @(negedge clk);
        push(1'b0, 7'h11, 8'h01, 8'h5A);
        push(1'b1, 7'h11, 8'h01, 8'h00);
        push(1'b0, 7'h11, 8'h02, 8'hC3);
        push(1'b1, 7'h11, 8'h02, 8'h00);
        check("full_level", fifo_level, 3'd4);
        check("full_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_reg_addr = 8'h00;
        repeat (3) @(negedge clk);
        check("stall_level", fifo_level, 3'd4);
        check("stall_enable", enable, 1'b0);
        stall = 1'b0;
        push(1'b1, 7'h11, 8'h00, 8'h00);
        wait_rsp("ord0", 1'b0, 8'h00, 1'b0);
        wait_rsp("ord1", 1'b1, 8'h5A, 1'b0);
        wait_rsp("ord2", 1'b0, 8'h00, 1'b0);
        wait_rsp("ord3", 1'b1, 8'hC3, 1'b0);
        wait_rsp("ord4", 1'b1, 8'hDC, 1'b0);
        check("drain_level", fifo_level, 3'd0);

        // 4: response back-pressure holds everything
        push(1'b0, 7'h11, 8'h03, 8'h77);
        push(1'b1, 7'h11, 8'h03, 8'h00);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rw || rsp_data != 8'h00 || rsp_err || enable) bad++;
        end
        check("hold_stable", bad, 0);
        check("hold_level", fifo_level, 3'd1);
        wait_rsp("hold_wr", 1'b0, 8'h00, 1'b0);
        wait_rsp("hold_rd", 1'b1, 8'h77, 1'b0);

        // 5: master disconnected -> start timeout
        master_on = 1'b0;
        divider = 16'h0040;
        push(1'b1, 7'h11, 8'h00, 8'h00);
        n = 0;
        while (!enable && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("tmo_enable", enable, 1'b1);
        check("tmo_div", m_divider, 16'h0040);
        n = 0; bad = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
            if (!rsp_valid && !enable) bad++;
        end
        check("tmo_cycles", n, 1024);
        check("tmo_enable_held", bad, 0);
        check("tmo_enable_low", enable, 1'b0);
        wait_rsp("tmo", 1'b1, 8'h00, 1'b1);
        master_on = 1'b1;

        // 6: reset in WAIT with two commands queued
        busy_len = 40;
        push(1'b0, 7'h11, 8'h05, 8'h99);
        @(negedge clk);
        check("mid_enable", enable, 1'b1);
        push(1'b0, 7'h11, 8'h06, 8'h11);
        push(1'b0, 7'h11, 8'h07, 8'h22);
        check("mid_level", fifo_level, 3'd2);
        check("mid_enable_low", enable, 1'b0);
        check("mid_rsp_valid", rsp_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_enable", enable, 1'b0);
        check("arst_level", fifo_level, 3'd0);
        check("arst_ready", cmd_ready, 1'b0);
        check("arst_dev", device_addr, 7'h00);
        check("arst_mosi", mosi_data, 8'h00);
        check("arst_div", m_divider, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (rsp_valid || enable || fifo_level != 3'd0) bad++;
        end
        check("post_arst_quiet", bad, 0);
        check("post_arst_ready", cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
